hart_scheduler: RTL and testbench

Barrel-issue controller that sequences the hart (hardware thread) whose instruction enters fetch and decode each cycle. It rotates a fixed-slot hart pointer and tracks each hart's run/sleep/off state. Issue bubbles are inserted for harts that are disabled or waiting on long-latency events. It sits ahead of fetch; the issued hart ID travels down the pipeline alongside the instruction word and its decoded fields.

---
 rtl/hart_scheduler_pkg.sv | 14 +
 rtl/hart_state_fsm.sv | 38 +++
 rtl/hart_scheduler.sv | 68 ++++++
 tb/tb_hart_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hart_scheduler_pkg.sv
// Shared definitions for the barrel-issue hart scheduler: hart state encoding
// and default sizing.
package hart_scheduler_pkg;

    typedef enum logic [1:0] {
        HS_OFF   = 2'b00,
        HS_RUN   = 2'b01,
        HS_SLEEP = 2'b10
    } hart_state_e;

    localparam int NUM_HARTS_DEFAULT = 16;
    localparam int HART_ID_W_DEFAULT = $clog2(NUM_HARTS_DEFAULT);

endpackage

// File: rtl/hart_state_fsm.sv
// Per-hart run/sleep/off state machine. Disable dominates; a wake in the same
// cycle as a sleep keeps the hart running.
module hart_state_fsm
    import hart_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sleep_hit,
    input  logic        wake_hit,
    output hart_state_e state
);

    hart_state_e state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HS_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = HS_OFF;
        end else begin
            case (state)
                HS_OFF:   state_next = HS_RUN;
                HS_RUN:   if (sleep_hit && !wake_hit) state_next = HS_SLEEP;
                HS_SLEEP: if (wake_hit) state_next = HS_RUN;
                default:  state_next = HS_OFF;
            endcase
        end
    end

endmodule

// File: rtl/hart_scheduler.sv
// Barrel-issue scheduler: fixed rotating slot pointer plus per-hart state.
// Optional bubble counter is built when HART_SCHED_PERF_EN is defined.
module hart_scheduler
    import hart_scheduler_pkg::*;
#(
    parameter int NUM_HARTS = NUM_HARTS_DEFAULT,
    parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HARTS-1:0] i_hart_en,
    input  logic                 i_sleep_valid,
    input  logic [HART_ID_W-1:0] i_sleep_hart,
    input  logic                 i_wake_valid,
    input  logic [HART_ID_W-1:0] i_wake_hart,
`ifdef HART_SCHED_PERF_EN
    output logic [31:0]          o_bubble_count,
`endif
    output logic                 o_issue_valid,
    output logic [HART_ID_W-1:0] o_issue_hart,
    output logic [NUM_HARTS-1:0] o_run_mask
);

    logic [HART_ID_W-1:0] slot;
    hart_state_e          hart_state [NUM_HARTS];

    // The slot never skips so each hart sees a fixed NUM_HARTS-cycle spacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
        logic sleep_hit;
        logic wake_hit;

        assign sleep_hit = i_sleep_valid && (i_sleep_hart == HART_ID_W'(i));
        assign wake_hit  = i_wake_valid  && (i_wake_hart  == HART_ID_W'(i));

        hart_state_fsm u_fsm (
            .clk       (clk),
            .reset     (reset),
            .enable    (i_hart_en[i]),
            .sleep_hit (sleep_hit),
            .wake_hit  (wake_hit),
            .state     (hart_state[i])
        );

        assign o_run_mask[i] = (hart_state[i] == HS_RUN);
    end

    assign o_issue_hart  = slot;
    assign o_issue_valid = o_run_mask[slot];

`ifdef HART_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_bubble_count <= '0;
        end else if (!o_issue_valid) begin
            o_bubble_count <= o_bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hart_scheduler.sv
// Directed bench for hart_scheduler; also checks the bubble counter when
// HART_SCHED_PERF_EN is defined.
module tb_hart_scheduler;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  i_hart_en;
    logic          i_sleep_valid;
    logic [IW-1:0] i_sleep_hart;
    logic          i_wake_valid;
    logic [IW-1:0] i_wake_hart;
    logic          o_issue_valid;
    logic [IW-1:0] o_issue_hart;
    logic [N-1:0]  o_run_mask;
`ifdef HART_SCHED_PERF_EN
    logic [31:0]   o_bubble_count;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_slot = 0;
    int s;

    always #5 clk = ~clk;

    hart_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .i_hart_en     (i_hart_en),
        .i_sleep_valid (i_sleep_valid),
        .i_sleep_hart  (i_sleep_hart),
        .i_wake_valid  (i_wake_valid),
        .i_wake_hart   (i_wake_hart),
`ifdef HART_SCHED_PERF_EN
        .o_bubble_count(o_bubble_count),
`endif
        .o_issue_valid (o_issue_valid),
        .o_issue_hart  (o_issue_hart),
        .o_run_mask    (o_run_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_slot = reset ? 0 : (exp_slot + 1) % N;
    endtask

    task automatic clear_req();
        i_sleep_valid = 1'b0;
        i_wake_valid  = 1'b0;
    endtask

    task automatic sleep_req(input int h);
        i_sleep_valid = 1'b1;
        i_sleep_hart  = IW'(h);
    endtask

    task automatic wake_req(input int h);
        i_wake_valid = 1'b1;
        i_wake_hart  = IW'(h);
    endtask

    initial begin
        reset = 1'b1;
        i_hart_en = 16'hFFFF;
        i_sleep_hart = '0;
        i_wake_hart = '0;
        clear_req();
        tick();
        tick();
        exp_slot = 0;
        reset = 1'b0;

        // First cycle after reset: slot 0, nothing running yet.
        check("rst_hart", 32'(o_issue_hart), 32'd0);
        check("rst_valid", 32'(o_issue_valid), 32'd0);
        check("rst_mask", 32'(o_run_mask), 32'h0);
`ifdef HART_SCHED_PERF_EN
        check("rst_bubbles", o_bubble_count, 32'd0);
`endif
        tick();
        check("en_mask", 32'(o_run_mask), 32'hFFFF);
        for (int c = 0; c < 18; c++) begin
            check("rot_hart", 32'(o_issue_hart), 32'((c + 1) % N));
            check("rot_valid", 32'(o_issue_valid), 32'd1);
            tick();
        end

        // Sleep hart 5: bubbles on its slot until woken.
        sleep_req(5);
        tick();
        clear_req();
        check("sleep5_mask", 32'(o_run_mask), 32'hFFDF);
        for (int c = 0; c < N; c++) begin
            check("sleep5_valid", 32'(o_issue_valid), 32'(exp_slot != 5));
            tick();
        end
        wake_req(5);
        tick();
        clear_req();
        check("wake5_mask", 32'(o_run_mask), 32'hFFFF);
        for (int c = 0; c < N; c++) begin
            check("wake5_valid", 32'(o_issue_valid), 32'd1);
            tick();
        end

        // Sleep on the hart's own slot: that slot still issues.
        s = exp_slot;
        check("own_slot_hart", 32'(o_issue_hart), 32'(s));
        sleep_req(s);
        check("own_slot_valid", 32'(o_issue_valid), 32'd1);
        tick();
        clear_req();
        check("own_slot_mask", 32'(o_run_mask), 32'hFFFF & ~(32'd1 << s));
        wake_req(s);
        tick();
        clear_req();
        check("own_slot_wake", 32'(o_run_mask), 32'hFFFF);

        // Sleep and wake together on a running hart: stays RUN.
        sleep_req(3);
        wake_req(3);
        tick();
        clear_req();
        check("sw3_mask", 32'(o_run_mask), 32'hFFFF);

        // Wake to a running hart leaves no pending record.
        wake_req(9);
        tick();
        clear_req();
        check("wake_run_mask", 32'(o_run_mask), 32'hFFFF);
        sleep_req(9);
        tick();
        clear_req();
        check("no_pending_mask", 32'(o_run_mask), 32'hFDFF);

        // Different harts in the same cycle: both applied.
        sleep_req(2);
        wake_req(9);
        tick();
        clear_req();
        check("dual_mask", 32'(o_run_mask), 32'hFFFB);
        wake_req(2);
        tick();
        clear_req();
        check("wake2_mask", 32'(o_run_mask), 32'hFFFF);

        // Sleep to an OFF hart is ignored; disable beats wake.
        sleep_req(7);
        tick();
        clear_req();
        check("sleep7_mask", 32'(o_run_mask), 32'hFF7F);
        i_hart_en = 16'hFF7F;
        wake_req(7);
        tick();
        clear_req();
        check("off7_mask", 32'(o_run_mask), 32'hFF7F);
        sleep_req(7);
        for (int c = 0; c < N; c++) begin
            check("off7_valid", 32'(o_issue_valid), 32'(exp_slot != 7));
            tick();
            clear_req();
        end
        i_hart_en = 16'hFFFF;
        tick();
        check("reen7_mask", 32'(o_run_mask), 32'hFFFF);

        // Reset mid-stream with a sleep in flight.
        sleep_req(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_req();
        check("mid_rst_mask", 32'(o_run_mask), 32'h0);
        check("mid_rst_hart", 32'(o_issue_hart), 32'd0);
        check("mid_rst_valid", 32'(o_issue_valid), 32'd0);
`ifdef HART_SCHED_PERF_EN
        check("mid_rst_bubbles", o_bubble_count, 32'd0);
`endif
        tick();
        check("post_rst_mask", 32'(o_run_mask), 32'hFFFF);
        check("post_rst_hart", 32'(o_issue_hart), 32'd1);
        check("post_rst_valid", 32'(o_issue_valid), 32'd1);

`ifdef HART_SCHED_PERF_EN
        // Only hart 0 enabled for 32 cycles: one issue (cycle 17), 31 bubbles.
        reset = 1'b1;
        i_hart_en = 16'h0001;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 32; c++) tick();
        check("perf_bubbles", o_bubble_count, 32'd31);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf_rst", o_bubble_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
